byte_queue: RTL and testbench

- Downstream consumer of the 1-bit deserializer.
- Accepts completed bytes on a level handshake (data_ready / ack_in) and stores them in a circular FIFO of DEPTH entries.
- Serves them to the output side on request.
- Runs entirely on the slow clock domain. The deserializer holds data_ready until it sees the ack, so the handshake is safe across the 100 kHz / 10 kHz pair without extra synchronisers.

---
 rtl/queue_pkg.sv | 6 +
 rtl/queue_mem.sv | 24 ++
 rtl/byte_queue.sv | 125 ++++++++++++
 tb/tb_byte_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and default sizing for the byte queue.
package queue_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} queue_state_t;
  localparam int QUEUE_DEPTH = 8;
  localparam int QUEUE_WIDTH = 8;
endpackage

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module queue_mem
  import queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = QUEUE_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/byte_queue.sv
// Circular byte FIFO fed by a level data_ready/ack handshake, popped on request.
// Build option: QUEUE_UNDERFLOW_ERR_EN enables the sticky underflow flag on error_out.
module byte_queue
  import queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = QUEUE_WIDTH
) (
  input  logic                     clock_10KHZ,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     enqueue_in,
  output logic                     ack_out,
  input  logic                     dequeue_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   len_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     error_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  queue_state_t     state_q, state_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [LW-1:0]    len_q, len_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rdata;
  logic             wr, rd;

  queue_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk   (clock_10KHZ),
    .we    (wr),
    .waddr (tail_q),
    .wdata (data_in),
    .raddr (head_q),
    .rdata (rdata)
  );

  // Write admission uses the registered full flag, so a same-edge pop never frees room early.
  assign wr = (state_q == IDLE) && enqueue_in && !full_q;
  assign rd = dequeue_in && !empty_q;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    head_d  = head_q;
    tail_d  = tail_q;
    len_d   = len_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: if (wr) begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      ACK: if (!enqueue_in) begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
    if (wr) tail_d = tail_q + AW'(1);
    if (rd) begin
      head_d = head_q + AW'(1);
      dout_d = rdata;
    end
    case ({wr, rd})
      2'b10:   len_d = len_q + LW'(1);
      2'b01:   len_d = len_q - LW'(1);
      default: len_d = len_q;
    endcase
    full_d  = (len_d == LW'(DEPTH));
    empty_d = (len_d == '0);
  end

  always_ff @(posedge clock_10KHZ) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

`ifdef QUEUE_UNDERFLOW_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (dequeue_in & empty_q);
  end

  always_ff @(posedge clock_10KHZ) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

  assign ack_out   = ack_q;
  assign data_out  = dout_q;
  assign len_out   = len_q;
  assign full_out  = full_q;
  assign empty_out = empty_q;
endmodule

// File: tb/tb_byte_queue.sv
// Directed bench for byte_queue: handshake, full/backpressure, wrap, same-edge push/pop, underflow, reset.
module tb_byte_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       empty_out;
  logic       error_out;

  int checks = 0;
  int errors = 0;
  logic exp_err;

  byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_10KHZ (clk),
    .reset       (reset),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .ack_out     (ack_out),
    .dequeue_in  (dequeue_in),
    .data_out    (data_out),
    .len_out     (len_out),
    .full_out    (full_out),
    .empty_out   (empty_out),
    .error_out   (error_out)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    data_in    = v;
    enqueue_in = 1'b1;
    tick();
    chk("push_ack", ack_out, 1);
    enqueue_in = 1'b0;
    tick();
    chk("push_ack_drop", ack_out, 0);
  endtask

  initial begin
`ifdef QUEUE_UNDERFLOW_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1; data_in = '0; enqueue_in = 1'b0; dequeue_in = 1'b0;
    tick(); tick();
    chk("rst_ack", ack_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_len", len_out, 0);
    chk("rst_full", full_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_err", error_out, 0);
    reset = 1'b0;

    // held data_ready: one write, ack stays high
    data_in = 8'hA5; enqueue_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ack", ack_out, 1);
      chk("hold_len", len_out, 1);
    end
    enqueue_in = 1'b0;
    tick();
    chk("hold_ack_drop", ack_out, 0);
    chk("hold_len_after", len_out, 1);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("hold_pop", data_out, 8'hA5);
    chk("hold_empty", empty_out, 1);

    // fill, backpressure, pop admits the waiting byte one edge later
    for (int v = 1; v <= 8; v++) push(8'(v));
    chk("fill_len", len_out, 8);
    chk("fill_full", full_out, 1);
    data_in = 8'h09; enqueue_in = 1'b1;
    tick();
    chk("full_noack", ack_out, 0);
    chk("full_len", len_out, 8);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("full_pop_data", data_out, 8'h01);
    chk("full_pop_noack", ack_out, 0);
    chk("full_pop_len", len_out, 7);
    tick();
    chk("late_ack", ack_out, 1);
    chk("late_len", len_out, 8);
    chk("late_full", full_out, 1);
    enqueue_in = 1'b0;
    tick();
    chk("late_ack_drop", ack_out, 0);

    // drain across the pointer wrap
    dequeue_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_data", data_out, 32'(i + 2));
    end
    dequeue_in = 1'b0;
    chk("drain_empty", empty_out, 1);
    chk("drain_len", len_out, 0);

    // simultaneous push and pop at len 3
    push(8'h11); push(8'h22); push(8'h33);
    chk("sim_pre_len", len_out, 3);
    data_in = 8'h3C; enqueue_in = 1'b1; dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("sim_len", len_out, 3);
    chk("sim_data", data_out, 8'h11);
    chk("sim_ack", ack_out, 1);
    enqueue_in = 1'b0;
    tick();
    dequeue_in = 1'b1;
    tick(); chk("sim_pop1", data_out, 8'h22);
    tick(); chk("sim_pop2", data_out, 8'h33);
    tick(); chk("sim_pop3", data_out, 8'h3C);
    chk("sim_empty", empty_out, 1);

    // underflow: still requesting pop while empty
    tick();
    dequeue_in = 1'b0;
    chk("uf_data", data_out, 8'h3C);
    chk("uf_len", len_out, 0);
    chk("uf_err", error_out, 32'(exp_err));
    tick();
    chk("uf_err_sticky", error_out, 32'(exp_err));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("uf_err_rst", error_out, 0);
    chk("uf_dout_rst", data_out, 0);

    // reset in the middle of a handshake
    push(8'h41); push(8'h42); push(8'h43);
    data_in = 8'h44; enqueue_in = 1'b1;
    tick();
    chk("mid_ack", ack_out, 1);
    chk("mid_len", len_out, 4);
    reset = 1'b1;
    tick();
    chk("mid_rst_len", len_out, 0);
    chk("mid_rst_ack", ack_out, 0);
    chk("mid_rst_empty", empty_out, 1);
    reset = 1'b0;
    tick();
    // FSM back in IDLE, so the still-held request is taken as a fresh write
    chk("mid_idle_ack", ack_out, 1);
    chk("mid_idle_len", len_out, 1);
    enqueue_in = 1'b0;
    tick();
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    chk("mid_idle_data", data_out, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
